// File: rtl/iddr_cell.sv
// Single-bit input DDR capture cell: samples D on both edges of C and presents the
// rising/falling slices on Q1/Q2 in one of three alignment modes (vendor IDDR semantics).
`timescale 1ns/1ps

module iddr_cell #(
    parameter string DDR_CLK_EDGE = "OPPOSITE_EDGE",
    parameter logic  INIT_Q1      = 1'b0,
    parameter logic  INIT_Q2      = 1'b0,
    parameter string SRTYPE       = "SYNC"
) (
    input  logic C,
    input  logic R,
    input  logic S,
    input  logic CE,
    input  logic D,
    output logic Q1,
    output logic Q2
);

    typedef enum logic [1:0] {
        MODE_OPPOSITE,
        MODE_SAME,
        MODE_PIPELINED
    } mode_e;

    // Unrecognised edge modes fall back to OPPOSITE_EDGE.
    localparam mode_e MODE = (DDR_CLK_EDGE == "SAME_EDGE")           ? MODE_SAME :
                             (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED") ? MODE_PIPELINED :
                                                                       MODE_OPPOSITE;

    if (DDR_CLK_EDGE != "OPPOSITE_EDGE" && DDR_CLK_EDGE != "SAME_EDGE" &&
        DDR_CLK_EDGE != "SAME_EDGE_PIPELINED") begin : g_bad_edge
        $info("iddr_cell error: unsupported DDR_CLK_EDGE \"%s\", behaving as OPPOSITE_EDGE",
              DDR_CLK_EDGE);
    end

    if (SRTYPE != "SYNC") begin : g_bad_srtype
        $info("iddr_cell error: unsupported SRTYPE \"%s\", treated as SYNC", SRTYPE);
    end

    // NOTE: power-up values come from declaration initialisers, not from R; R/S only
    // act synchronously, so the registers must already hold INIT_* before any edge.
    logic rise_cap = INIT_Q1;
    logic q1_pipe  = INIT_Q1;
    logic fall_cap = INIT_Q2;
    logic q2_reg   = INIT_Q2;

    // Reset beats set, set beats clock enable; with none active the register holds.
    function automatic logic next_val(input logic cur, input logic rst, input logic set,
                                      input logic en, input logic din);
        if (rst)
            return 1'b0;
        else if (set)
            return 1'b1;
        else if (en)
            return din;
        else
            return cur;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so q1_pipe/q2_reg see the
    // pre-edge rise_cap/fall_cap values regardless of statement order.
    always_ff @(posedge C) begin
        rise_cap <= next_val(rise_cap, R, S, CE, D);
        q1_pipe  <= next_val(q1_pipe,  R, S, CE, rise_cap);
        q2_reg   <= next_val(q2_reg,   R, S, CE, fall_cap);
    end

    // The falling-edge slice samples R/S/CE on its own edge.
    always_ff @(negedge C) begin
        fall_cap <= next_val(fall_cap, R, S, CE, D);
    end

    assign Q1 = (MODE == MODE_PIPELINED) ? q1_pipe : rise_cap;
    assign Q2 = (MODE == MODE_OPPOSITE)  ? fall_cap : q2_reg;

endmodule

// File: tb/tb_iddr_cell.sv
// Self-checking bench for iddr_cell: four instances (opposite, same, pipelined, invalid
// mode) share one stimulus stream and are compared against a slice-level reference model.
`timescale 1ns/1ps

module tb_iddr_cell;

    localparam int OPP  = 0;
    localparam int SAME = 1;
    localparam int PIPE = 2;

    logic       C  = 1'b0;
    logic       R  = 1'b0;
    logic       S  = 1'b0;
    logic       CE = 1'b1;
    logic       D  = 1'b0;
    logic [3:0] q1;
    logic [3:0] q2;

    int total = 0;
    int bad   = 0;

    // Instance index -> alignment mode and power-up values.
    int   mode_of [4] = '{OPP, SAME, PIPE, OPP};
    logic init1   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic init2   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reference model: latest rising slice, latest falling slice, and the pair as
    // re-timed onto the rising edge (used by SAME_EDGE Q2 and both PIPELINED outputs).
    logic m_rise [4];
    logic m_fall [4];
    logic m_p1   [4];
    logic m_p2   [4];

    iddr_cell #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT_Q1(1'b0), .INIT_Q2(1'b0), .SRTYPE("SYNC"))
        u_opp  (.C(C), .R(R), .S(S), .CE(CE), .D(D), .Q1(q1[0]), .Q2(q2[0]));
    iddr_cell #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT_Q1(1'b0), .INIT_Q2(1'b0), .SRTYPE("SYNC"))
        u_same (.C(C), .R(R), .S(S), .CE(CE), .D(D), .Q1(q1[1]), .Q2(q2[1]));
    iddr_cell #(.DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .INIT_Q1(1'b1), .INIT_Q2(1'b1), .SRTYPE("SYNC"))
        u_pipe (.C(C), .R(R), .S(S), .CE(CE), .D(D), .Q1(q1[2]), .Q2(q2[2]));
    iddr_cell #(.DDR_CLK_EDGE("FOO"), .INIT_Q1(1'b0), .INIT_Q2(1'b0), .SRTYPE("SYNC"))
        u_foo  (.C(C), .R(R), .S(S), .CE(CE), .D(D), .Q1(q1[3]), .Q2(q2[3]));

    always #5 C = ~C;

    function automatic logic slice(input logic cur, input logic r, input logic s,
                                   input logic ce, input logic d);
        if (r)       return 1'b0;
        else if (s)  return 1'b1;
        else if (ce) return d;
        else         return cur;
    endfunction

    function automatic logic exp_q1(input int i);
        return (mode_of[i] == PIPE) ? m_p1[i] : m_rise[i];
    endfunction

    function automatic logic exp_q2(input int i);
        return (mode_of[i] == OPP) ? m_fall[i] : m_p2[i];
    endfunction

    // Drive one rising-edge half-cycle, advance the model, settle 1ns past the edge.
    task automatic step_rise(input logic d, input logic r, input logic s, input logic ce);
        D = d; R = r; S = s; CE = ce;
        @(posedge C);
        for (int i = 0; i < 4; i++) begin
            m_p1[i]   = slice(m_p1[i], r, s, ce, m_rise[i]);
            m_p2[i]   = slice(m_p2[i], r, s, ce, m_fall[i]);
            m_rise[i] = slice(m_rise[i], r, s, ce, d);
        end
        #1;
    endtask

    task automatic step_fall(input logic d, input logic r, input logic s, input logic ce);
        D = d; R = r; S = s; CE = ce;
        @(negedge C);
        for (int i = 0; i < 4; i++)
            m_fall[i] = slice(m_fall[i], r, s, ce, d);
        #1;
    endtask

    task automatic test_reset;
        total++;
        if (q1 !== 4'b0100 || q2 !== 4'b0100) begin
            bad++;
            $display("FAIL powerup got q1=%b q2=%b want q1=0100 q2=0100", q1, q2);
        end
    endtask

    task automatic test_pipelined_pattern;
        logic w2;
        for (int k = 1; k <= 3; k++) begin
            w2 = (k == 1);
            step_rise(1'b1, 1'b0, 1'b0, 1'b1);
            total++;
            if (q1[2] !== 1'b1 || q2[2] !== w2) begin
                bad++;
                $display("FAIL pipe_pattern pos%0d got %b/%b want 1/%b", k, q1[2], q2[2], w2);
            end
            step_fall(1'b0, 1'b0, 1'b0, 1'b1);
            total++;
            if (q1[2] !== 1'b1 || q2[2] !== w2) begin
                bad++;
                $display("FAIL pipe_pattern neg%0d got %b/%b want 1/%b", k, q1[2], q2[2], w2);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q1[i] !== exp_q1(i) || q2[i] !== exp_q2(i)) begin
                    bad++;
                    $display("FAIL pipe_pattern_model dut%0d got %b/%b want %b/%b",
                             i, q1[i], q2[i], exp_q1(i), exp_q2(i));
                end
            end
        end
    endtask

    task automatic test_opposite;
        step_rise(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (q1[0] !== 1'b0 || q2[0] !== 1'b0 || q1[3] !== 1'b0 || q2[3] !== 1'b0) begin
            bad++;
            $display("FAIL opposite_pos got opp=%b/%b foo=%b/%b want 0/0", q1[0], q2[0], q1[3], q2[3]);
        end
        step_fall(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (q1[0] !== 1'b0 || q2[0] !== 1'b1 || q1[3] !== 1'b0 || q2[3] !== 1'b1) begin
            bad++;
            $display("FAIL opposite_neg got opp=%b/%b foo=%b/%b want 0/1", q1[0], q2[0], q1[3], q2[3]);
        end
    endtask

    task automatic test_same_edge;
        step_rise(1'b1, 1'b0, 1'b0, 1'b1);
        step_fall(1'b0, 1'b0, 1'b0, 1'b1);
        step_rise(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (q1[1] !== 1'b0 || q2[1] !== 1'b0) begin
            bad++;
            $display("FAIL same_pos1 got %b/%b want 0/0", q1[1], q2[1]);
        end
        step_fall(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (q2[1] !== 1'b0) begin
            bad++;
            $display("FAIL same_neg1 got Q2=%b want 0", q2[1]);
        end
        step_rise(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (q2[1] !== 1'b1) begin
            bad++;
            $display("FAIL same_pos2 got Q2=%b want 1", q2[1]);
        end
        step_fall(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_set;
        for (int k = 0; k < 2; k++) begin
            step_rise(1'b0, 1'b0, 1'b1, 1'b1);
            total++;
            if (q1 !== 4'b1111 || q2[1] !== 1'b1 || q2[2] !== 1'b1) begin
                bad++;
                $display("FAIL set_pos%0d got q1=%b q2=%b want q1=1111 same/pipe Q2=1", k, q1, q2);
            end
            step_fall(1'b0, 1'b0, 1'b1, 1'b1);
            total++;
            if (q2 !== 4'b1111) begin
                bad++;
                $display("FAIL set_neg%0d got q2=%b want 1111", k, q2);
            end
        end
        step_rise(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (q1[2] !== 1'b1 || q2[2] !== 1'b1) begin
            bad++;
            $display("FAIL set_release1 got pipe %b/%b want 1/1", q1[2], q2[2]);
        end
        step_fall(1'b0, 1'b0, 1'b0, 1'b1);
        step_rise(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (q1[2] !== 1'b0 || q2[2] !== 1'b0) begin
            bad++;
            $display("FAIL set_release2 got pipe %b/%b want 0/0", q1[2], q2[2]);
        end
        step_fall(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_and_set;
        step_rise(1'b1, 1'b0, 1'b1, 1'b1);
        step_fall(1'b1, 1'b0, 1'b1, 1'b1);
        step_rise(1'b1, 1'b1, 1'b1, 1'b1);
        step_fall(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (q1 !== 4'b0000 || q2 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_and_set got q1=%b q2=%b want 0000/0000", q1, q2);
        end
    endtask

    task automatic test_ce_hold;
        logic s1 [4];
        logic s2 [4];
        step_rise(1'b1, 1'b0, 1'b0, 1'b1);
        step_fall(1'b0, 1'b0, 1'b0, 1'b1);
        step_rise(1'b0, 1'b0, 1'b0, 1'b1);
        step_fall(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            s1[i] = exp_q1(i);
            s2[i] = exp_q2(i);
        end
        for (int k = 0; k < 3; k++) begin
            step_rise(k[0], 1'b0, 1'b0, 1'b0);
            step_fall(~k[0], 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q1[i] !== s1[i] || q2[i] !== s2[i]) begin
                    bad++;
                    $display("FAIL ce_hold dut%0d cyc%0d got %b/%b want %b/%b",
                             i, k, q1[i], q2[i], s1[i], s2[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic d, r, s, ce;
        for (int k = 0; k < 600; k++) begin
            d  = 1'($urandom);
            r  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 7) == 0);
            ce = ($urandom_range(0, 3) != 0);
            if (k[0] == 1'b0) step_rise(d, r, s, ce);
            else              step_fall(d, r, s, ce);
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q1[i] !== exp_q1(i) || q2[i] !== exp_q2(i)) begin
                    bad++;
                    $display("FAIL random dut%0d step%0d got %b/%b want %b/%b",
                             i, k, q1[i], q2[i], exp_q1(i), exp_q2(i));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_rise[i] = init1[i];
            m_p1[i]   = init1[i];
            m_fall[i] = init2[i];
            m_p2[i]   = init2[i];
        end
        #1;
        test_reset;
        test_pipelined_pattern;
        test_opposite;
        test_same_edge;
        test_set;
        test_reset_and_set;
        test_ce_hold;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
